// File: rtl/adsr_pkg.sv
// Shared constants and helpers for the ADSR envelope generator.
package adsr_pkg;

  // State codes; 5..7 are unreachable and fall back to idle.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // Level width and full-scale level for the default WIDTH=8, FRAC=8 build.
  localparam int unsigned LW_DEF    = 16;
  localparam logic [LW_DEF-1:0] LEVEL_MAX = '1;

  // A rate of zero would freeze the envelope, so it is promoted to one LSB.
  function automatic logic [7:0] rate_nz(input logic [7:0] r);
    return (r == 8'd0) ? 8'd1 : r;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Envelope tick prescaler: one-clock tick every DIV clocks.
module tick_div #(
  parameter int unsigned DIV = 256
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Free-running 0..DIV-1 counter, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope generator: gate-driven attack/decay/sustain/release level
// with tick-rate stepping and saturating arithmetic.
// The rate input for the release phase is named release_rate because
// "release" is a reserved word in SystemVerilog.
module adsr_env
  import adsr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned DIV   = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gate,
  input  logic [7:0]       attack,
  input  logic [7:0]       decay,
  input  logic [WIDTH-1:0] sustain,
  input  logic [7:0]       release_rate,
  output logic [WIDTH-1:0] cv,
  output logic             active,
  output logic [2:0]       state
);

  localparam int unsigned LW = WIDTH + FRAC;
  localparam logic [LW-1:0] LVL_MAX = '1;

  logic          tick;
  logic          gate_q;
  logic          rise;
  logic          fall;
  logic [LW-1:0] level;
  logic [LW-1:0] level_n;
  logic [2:0]    state_n;
  logic [LW-1:0] att_w;
  logic [LW-1:0] dec_w;
  logic [LW-1:0] rel_w;
  logic [LW-1:0] sus_w;
  logic [LW:0]   sum_x;
  logic [LW:0]   thr_x;

  tick_div #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign rise  = gate & ~gate_q;
  assign fall  = ~gate & gate_q;

  assign att_w = LW'(rate_nz(attack));
  assign dec_w = LW'(rate_nz(decay));
  assign rel_w = LW'(rate_nz(release_rate));
  assign sus_w = LW'(sustain) << FRAC;

  // One extra bit so neither the attack sum nor the decay threshold can wrap.
  assign sum_x = {1'b0, level} + {1'b0, att_w};
  assign thr_x = {1'b0, sus_w} + {1'b0, dec_w};

  // Next-state/next-level: gate edges take priority over the tick step.
  always_comb begin
    state_n = state;
    level_n = level;
    if (state > ST_RELEASE) begin
      state_n = ST_IDLE;
      level_n = '0;
    end else if (rise) begin
      state_n = ST_ATTACK;
    end else if (fall && (state == ST_ATTACK || state == ST_DECAY ||
                          state == ST_SUSTAIN)) begin
      state_n = ST_RELEASE;
    end else if (state == ST_IDLE) begin
      level_n = '0;
    end else if (tick) begin
      case (state)
        ST_ATTACK: begin
          if (sum_x >= {1'b0, LVL_MAX}) begin
            level_n = LVL_MAX;
            state_n = ST_DECAY;
          end else begin
            level_n = sum_x[LW-1:0];
          end
        end
        ST_DECAY: begin
          // level - decay <= S, rewritten so the subtraction cannot underflow
          if ({1'b0, level} <= thr_x) begin
            level_n = sus_w;
            state_n = ST_SUSTAIN;
          end else begin
            level_n = level - dec_w;
          end
        end
        ST_SUSTAIN: begin
          level_n = sus_w;
        end
        ST_RELEASE: begin
          if (level <= rel_w) begin
            level_n = '0;
            state_n = ST_IDLE;
          end else begin
            level_n = level - rel_w;
          end
        end
        default: begin
          state_n = ST_IDLE;
          level_n = '0;
        end
      endcase
    end
  end

  // Envelope registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_q <= 1'b0;
      level  <= '0;
      state  <= ST_IDLE;
    end else begin
      gate_q <= gate;
      level  <= level_n;
      state  <= state_n;
    end
  end

  assign cv     = level[LW-1:FRAC];
  assign active = (state != ST_IDLE);

endmodule

// File: tb/tb_adsr_env.sv
// Directed table-driven bench for adsr_env (DIV=4, WIDTH=8, FRAC=8).
module tb_adsr_env;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gate = 1'b0;
  logic [7:0] attack = '0;
  logic [7:0] decay = '0;
  logic [7:0] sustain = '0;
  logic [7:0] rel = '0;
  logic [7:0] cv;
  logic       active;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;   // clock edges since the last reset edge

  adsr_env #(.WIDTH(8), .FRAC(8), .DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gate         (gate),
    .attack       (attack),
    .decay        (decay),
    .sustain      (sustain),
    .release_rate (rel),
    .cv           (cv),
    .active       (active),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       g;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] s;
    logic [7:0] r;
    bit         tk;   // 1: n counts ticks, 0: n counts clocks
    int         n;
    int         cv;
    int         st;
    int         act;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic g, input int a, input int d, input int s,
                     input int r, input bit tk, input int n, input int ecv,
                     input int est, input int eact);
    vec_t v;
    v.g = g; v.a = 8'(a); v.d = 8'(d); v.s = 8'(s); v.r = 8'(r);
    v.tk = tk; v.n = n; v.cv = ecv; v.st = est; v.act = eact;
    vecs.push_back(v);
  endtask

  task automatic clk1();
    @(posedge clk);
    if (!rst_n) k = 0;
    else k++;
    #1;
  endtask

  // With DIV=4 the prescaler ticks on every 4th edge after the reset edge.
  task automatic run(input bit tk, input int n);
    int got = 0;
    while (got < n) begin
      clk1();
      if (!tk || (k > 0 && k % 4 == 0)) got++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    //   g  atk dec sus rel tk  n    cv  st act
    // Full A-D-S-R cycle
    add(1, 255, 255, 8'h80, 128, 1, 256, 255, 1, 1);
    add(1, 255, 255, 8'h80, 128, 1,   1, 255, 2, 1);
    add(1, 255, 255, 8'h80, 128, 1, 128, 128, 2, 1);
    add(1, 255, 255, 8'h80, 128, 1,   1, 128, 3, 1);
    add(1, 255, 255, 8'h40, 128, 1,   1,  64, 3, 1);
    add(1, 255, 255, 8'h80, 128, 1,   1, 128, 3, 1);
    add(0, 255, 255, 8'h80, 128, 1,   1, 127, 4, 1);
    add(0, 255, 255, 8'h80, 128, 1, 254,   0, 4, 1);
    add(0, 255, 255, 8'h80, 128, 1,   1,   0, 0, 0);
    // Zero rates act as one LSB per tick
    add(1,   0,   0, 8'h80,   0, 1, 255,   0, 1, 1);
    add(1,   0,   0, 8'h80,   0, 1,   1,   1, 1, 1);
    add(0,   0,   0, 8'h80,   0, 1,   1,   0, 4, 1);
    add(0,   0,   0, 8'h80,   0, 1, 254,   0, 4, 1);
    add(0,   0,   0, 8'h80,   0, 1,   1,   0, 0, 0);
    // Retrigger from release keeps the current level
    add(1, 202,   0, 8'h80, 128, 1, 128, 101, 1, 1);
    add(0, 202,   0, 8'h80, 128, 1,   2, 100, 4, 1);
    add(1, 202,   0, 8'h80, 128, 0,   1, 100, 1, 1);
    add(1, 202,   0, 8'h80, 128, 1,   1, 100, 1, 1);
    add(1, 202,   0, 8'h80, 128, 1,   1, 101, 1, 1);
    // Gate edges landing on a tick edge: state moves, level does not
    add(1, 202,   0, 8'h80, 255, 0,   3, 101, 1, 1);
    add(0, 202,   0, 8'h80, 255, 0,   1, 101, 4, 1);
    add(0, 202,   0, 8'h80, 255, 1,   1, 100, 4, 1);
    add(0, 202,   0, 8'h80, 255, 0,   3, 100, 4, 1);
    add(1, 202,   0, 8'h80, 255, 0,   1, 100, 1, 1);
    add(1, 202,   0, 8'h80, 255, 1,   1, 101, 1, 1);

    // Power-on reset
    rst_n = 1'b0;
    clk1();
    clk1();
    chk("reset cv", int'(cv), 0);
    chk("reset state", int'(state), 0);
    chk("reset active", int'(active), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      gate = vecs[i].g; attack = vecs[i].a; decay = vecs[i].d;
      sustain = vecs[i].s; rel = vecs[i].r;
      run(vecs[i].tk, vecs[i].n);
      chk($sformatf("row%0d cv", i), int'(cv), vecs[i].cv);
      chk($sformatf("row%0d state", i), int'(state), vecs[i].st);
      chk($sformatf("row%0d active", i), int'(active), vecs[i].act);
    end

    // One-clock reset mid-attack with gate held high
    attack = 8'd255;
    rst_n = 1'b0;
    clk1();
    chk("midrst cv", int'(cv), 0);
    chk("midrst state", int'(state), 0);
    chk("midrst active", int'(active), 0);
    chk("midrst prescaler", int'(dut.u_div.count), 0);
    rst_n = 1'b1;
    clk1();
    chk("rerise state", int'(state), 1);
    chk("rerise cv", int'(cv), 0);
    run(0, 6);
    chk("rerise pre-tick2 cv", int'(cv), 0);
    run(0, 1);
    chk("rerise tick2 cv", int'(cv), 1);
    chk("rerise tick2 state", int'(state), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adsr_env.md
ADSR_ENV -- requirements
Module: adsr_env

Interface
REQ-001 Parameter WIDTH, default 8: width of cv output and of sustain input.
REQ-002 Parameter FRAC, default 8: fractional bits of internal level; level width LW = WIDTH+FRAC.
REQ-003 Parameter DIV, default 256: clocks per envelope tick, DIV >= 2.
REQ-004 clk  input  1  single clock, all logic on posedge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 gate  input  1  note gate, 1 = key held; synchronous to clk.
REQ-007 attack  input  8  level increment per tick in ATTACK, in LSBs of level.
REQ-008 decay  input  8  level decrement per tick in DECAY.
REQ-009 sustain  input  WIDTH  sustain level, unsigned; S = sustain << FRAC.
REQ-010 release  input  8  level decrement per tick in RELEASE.
REQ-011 cv  output  WIDTH  unsigned envelope, level[LW-1:FRAC], direct drive for the VCA cv input.
REQ-012 active  output  1  1 when state != IDLE.
REQ-013 state  output  3  current state code.

Function
REQ-014 Prescaler counts 0..DIV-1 and wraps; tick is high for the one clock where count = DIV-1.
REQ-015 States IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; codes 5..7 unreachable, recover to IDLE on next clock.
REQ-016 gate registered into gate_q each clock; rise = gate & ~gate_q, fall = ~gate & gate_q.
REQ-017 On rise, from any state, state becomes ATTACK at that clock edge; level retained (no restart from 0).
REQ-018 On fall in ATTACK, DECAY or SUSTAIN, state becomes RELEASE at that clock edge; fall in IDLE/RELEASE ignored.
REQ-019 Gate event and tick in same clock: state change applies, no level step that clock.
REQ-020 Rate inputs of 0 treated as 1 (envelope never stalls).
REQ-021 ATTACK tick: if level + attack >= 2^LW-1, level = 2^LW-1 and state = DECAY; else level += attack.
REQ-022 DECAY tick: if level <= S or level - decay <= S, level = S and state = SUSTAIN; else level -= decay.
REQ-023 SUSTAIN tick: level = S (tracks sustain changes, steps directly).
REQ-024 RELEASE tick: if level <= release, level = 0 and state = IDLE; else level -= release.
REQ-025 IDLE: level held at 0.
REQ-026 Arithmetic in LW+1 bits unsigned; no wrap-around in either direction.
REQ-027 cv, active, state are registered values; cv changes at the same edge level changes (latency 0 from level register).
REQ-028 Rate and sustain inputs sampled only on tick clocks; may change any time.

Reset
REQ-029 rst_n low at a clock edge: level = 0, state = IDLE, prescaler = 0, gate_q = 0; cv = 0, active = 0, state = 0 from next edge.
REQ-030 Reset mid-operation discards envelope; gate held high through reset release produces a rise on first clock with rst_n high.

Structure
REQ-031 Package adsr_pkg holds state codes and the LW-wide maximum-level constant.
REQ-032 Prescaler is sub-module tick_div (parameter DIV, ports clk, rst_n, tick); remainder in adsr_env.

Verification (bench DIV=4, WIDTH=8, FRAC=8)
REQ-033 attack=255, gate 0->1 -> ATTACK; after 257 ticks level=0xFFFF, cv=255, state=DECAY.
REQ-034 Continue with decay=255, sustain=0x80 -> after 129 ticks level=0x8000, cv=128, state=SUSTAIN; sustain changed to 0x40 -> cv=64 on next tick.
REQ-035 gate 1->0 in SUSTAIN (cv=128), release=128 -> RELEASE; after 256 ticks level=0, cv=0, state=IDLE, active=0.
REQ-036 Retrigger: gate low in RELEASE at cv=100, gate high again -> ATTACK from level unchanged (cv=100), rises from there.
REQ-037 attack=0 -> level rises 1 LSB per tick (cv=1 after 256 ticks); gate edge coincident with tick -> state changes, level unchanged that clock.
REQ-038 rst_n low for one clock mid-ATTACK -> cv=0, state=IDLE, prescaler=0; gate still high -> ATTACK re-entered on first clock after reset.
